// File: rtl/sub32_unsigned_pkg.sv
// Shared constants and types for the 32-bit unsigned subtractor.
package sub32_unsigned_pkg;

   localparam int unsigned SUB_WIDTH = 32;
   localparam int unsigned SLICE_W   = 4;

   typedef logic [SUB_WIDTH-1:0] word_t;

endpackage : sub32_unsigned_pkg

// File: rtl/sub32_unsigned_sub_borrow_blk4.sv
// 4-bit borrow-lookahead subtract slice: diff = a - b - bin, with group propagate/generate.
module sub_borrow_blk4
   import sub32_unsigned_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_bin,
   output logic [SLICE_W-1:0] o_diff,
   output logic               o_bout,
   output logic               o_gp,
   output logic               o_gg
);

   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_p;
   logic [SLICE_W-1:0] w_c;

   // A bit generates a borrow when a=0,b=1; it passes an incoming borrow when a==b.
   assign w_g = ~i_a & i_b;
   assign w_p = ~(i_a ^ i_b);

   assign w_c[0] = i_bin;
   assign w_c[1] = w_g[0] | (w_p[0] & i_bin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_bin);

   assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign o_gp = &w_p;

   assign o_bout = o_gg | (o_gp & i_bin);
   assign o_diff = i_a ^ i_b ^ w_c;

endmodule : sub_borrow_blk4

// File: rtl/sub32_unsigned.sv
// Unsigned subtractor: combinational A - B with borrow, plus registered copy and sticky borrow.
module sub32_unsigned
   import sub32_unsigned_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             clr_sticky,
   output logic [WIDTH-1:0] result,
   output logic             borrow,
   output logic [WIDTH-1:0] result_q,
   output logic             borrow_q,
   output logic             borrow_sticky
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;

   logic [WIDTH-1:0] w_diff;
   logic [NSLICE:0]  w_bin;
   logic [NSLICE-1:0] w_gp;
   logic [NSLICE-1:0] w_gg;
   logic             w_borrow_la;

   logic [WIDTH-1:0] r_result_q;
   logic             r_borrow_q;
   logic             r_sticky;

   assign w_bin[0] = 1'b0;

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      sub_borrow_blk4 u_blk (
         .i_a    (A[gi*SLICE_W +: SLICE_W]),
         .i_b    (B[gi*SLICE_W +: SLICE_W]),
         .i_bin  (w_bin[gi]),
         .o_diff (w_diff[gi*SLICE_W +: SLICE_W]),
         .o_bout (w_bin[gi+1]),
         .o_gp   (w_gp[gi]),
         .o_gg   (w_gg[gi])
      );
   end

   assign result = w_diff;
   assign borrow = w_bin[NSLICE];

   // Group-level lookahead gives the clocked stage its own borrow, independent of the slice chain.
   always_comb begin
      w_borrow_la = 1'b0;
      for (int k = 0; k < NSLICE; k++) begin
         w_borrow_la = w_gg[k] | (w_gp[k] & w_borrow_la);
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result_q <= '0;
         r_borrow_q <= 1'b0;
      end else begin
         r_result_q <= w_diff;
         r_borrow_q <= w_borrow_la;
      end
   end

   // Sticky borrow flag; clear has priority over a new borrow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (clr_sticky) begin
         r_sticky <= 1'b0;
      end else if (w_borrow_la) begin
         r_sticky <= 1'b1;
      end else begin
         r_sticky <= r_sticky;
      end
   end

   assign result_q      = r_result_q;
   assign borrow_q      = r_borrow_q;
   assign borrow_sticky = r_sticky;

endmodule : sub32_unsigned

// File: tb/tb_sub32_unsigned.sv
// Directed and sweep checks of the unsigned subtractor and its registered/sticky outputs.
module tb_sub32_unsigned;
   import sub32_unsigned_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   word_t a_in = '0;
   word_t b_in = '0;
   logic  clr = 1'b0;
   word_t result, result_q;
   logic  borrow, borrow_q, sticky;

   int total = 0;
   int bad   = 0;

   sub32_unsigned dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .A             (a_in),
      .B             (b_in),
      .clr_sticky    (clr),
      .result        (result),
      .borrow        (borrow),
      .result_q      (result_q),
      .borrow_q      (borrow_q),
      .borrow_sticky (sticky)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      #2;
      total++;
      if ({result_q, borrow_q, sticky} !== {32'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_init: got rq=%h bq=%b st=%b want 0 0 0", result_q, borrow_q, sticky);
      end
   endtask

   task automatic test_directed();
      word_t va [10] = '{32'd123456789, 32'd0, 32'hFFFFFFFF, 32'd3000000000, 32'd1000000000,
                         32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
      word_t vb [10] = '{32'd123456789, 32'd0, 32'hFFFFFFFF, 32'd1000000000, 32'd3000000000,
                         32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000001};
      word_t vr [10] = '{32'd0, 32'd0, 32'd0, 32'd2000000000, 32'h88CA6C00,
                         32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic  vw [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         a_in = va[i];
         b_in = vb[i];
         #5;
         total++;
         if (result !== vr[i] || borrow !== vw[i]) begin
            bad++;
            $display("FAIL directed[%0d]: A=%h B=%h got %h/%b want %h/%b",
                     i, va[i], vb[i], result, borrow, vr[i], vw[i]);
         end
      end
   endtask

   task automatic test_sweep_small();
      word_t exp_r;
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib++) begin
            a_in  = ia;
            b_in  = ib;
            exp_r = a_in - b_in;
            #5;
            total++;
            if (result !== exp_r || borrow !== (ia < ib)) begin
               bad++;
               $display("FAIL sweep: A=%0d B=%0d got %h/%b want %h/%b",
                        ia, ib, result, borrow, exp_r, (ia < ib));
            end
         end
      end
   endtask

   task automatic test_random();
      word_t exp_r;
      logic  exp_b;
      for (int i = 0; i < 20000; i++) begin
         a_in  = $urandom;
         b_in  = (i % 8 == 0) ? a_in ^ (32'h1 << (i % 32)) : $urandom;
         exp_r = a_in - b_in;
         exp_b = (a_in < b_in);
         #5;
         total++;
         if (result !== exp_r || borrow !== exp_b) begin
            bad++;
            $display("FAIL random: A=%h B=%h got %h/%b want %h/%b",
                     a_in, b_in, result, borrow, exp_r, exp_b);
         end
      end
   endtask

   task automatic test_clocked();
      @(negedge clk);
      rst_n = 1'b1;
      clr   = 1'b0;
      a_in  = 32'd7;
      b_in  = 32'd9;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({result_q, borrow_q, sticky} !== {32'h0, 1'b0, 1'b0} || result !== 32'hFFFFFFFE
          || borrow !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: got rq=%h bq=%b st=%b r=%h b=%b want 0 0 0 fffffffe 1",
                  result_q, borrow_q, sticky, result, borrow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a_in  = 32'd0;
      b_in  = 32'd1;
      @(posedge clk);
      #1;
      total++;
      if (result_q !== 32'hFFFFFFFF || borrow_q !== 1'b1 || sticky !== 1'b1) begin
         bad++;
         $display("FAIL borrow_load: got rq=%h bq=%b st=%b want ffffffff 1 1", result_q, borrow_q, sticky);
      end
      @(negedge clk);
      a_in = 32'd5;
      b_in = 32'd2;
      @(posedge clk);
      #1;
      total++;
      if (result_q !== 32'd3 || borrow_q !== 1'b0 || sticky !== 1'b1) begin
         bad++;
         $display("FAIL sticky_hold: got rq=%h bq=%b st=%b want 3 0 1", result_q, borrow_q, sticky);
      end
      @(negedge clk);
      a_in = 32'd0;
      b_in = 32'd1;
      clr  = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (borrow_q !== 1'b1 || sticky !== 1'b0) begin
         bad++;
         $display("FAIL clear_wins: got bq=%b st=%b want 1 0", borrow_q, sticky);
      end
      @(negedge clk);
      clr = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (sticky !== 1'b1) begin
         bad++;
         $display("FAIL sticky_reset_after_clear: got st=%b want 1", sticky);
      end
      @(negedge clk);
      a_in = 32'd5;
      b_in = 32'd2;
      clr  = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (sticky !== 1'b0) begin
         bad++;
         $display("FAIL clear_no_borrow: got st=%b want 0", sticky);
      end
      @(negedge clk);
      clr = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (sticky !== 1'b0 || borrow_q !== 1'b0 || result_q !== 32'd3) begin
         bad++;
         $display("FAIL sticky_stays_clear: got rq=%h bq=%b st=%b want 3 0 0", result_q, borrow_q, sticky);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sweep_small();
      test_random();
      test_clocked();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sub32_unsigned
